// File: rtl/pe_inj_arb.sv
// pe_inj_arb: round-robin arbiter that merges NREQ PE flit streams onto one router injection port.
// Optional macro PE_ARB_CREDIT_EN enables per-VC credit counters and the sticky err flag.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b11
`endif

module pe_inj_arb #(
  parameter int NREQ    = 4,
  parameter int CREDITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(`DATAW+1)-1:0] idata,
  input  logic [NREQ-1:0]            ivalid,
  input  logic [NREQ*(`VCHW+1)-1:0]  ivch,
  input  logic [1:0]                 icredit,
  output logic [NREQ-1:0]            grt,
  output logic [`DATAW:0]            odata,
  output logic                       ovalid,
  output logic [`VCHW:0]             ovch,
  output logic [1:0]                 state,
  output logic                       err
);
  localparam int FW = `DATAW + 1;
  localparam int VW = `VCHW + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, ARB = 2'b01, XFER = 2'b10} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] own_q, own_d;
  logic [VW-1:0] vc_own_q, vc_own_d;
  logic [FW-1:0] odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic [VW-1:0] ovch_q, ovch_d;
  logic          cred_ok;
  logic          acc;
  logic [IW-1:0] win, cand;
  logic [VW-1:0] win_vc;
  logic [FW-1:0] own_flit;
  int            s;

  // Winner search: walk downward so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    win  = rr_ptr_q;
    s    = 0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      cand = IW'(s);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    win_vc   = '0;
    own_flit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i))   win_vc   = ivch[i*VW +: VW];
      if (own_q == IW'(i)) own_flit = idata[i*FW +: FW];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    own_d    = own_q;
    vc_own_d = vc_own_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    ovch_d   = ovch_q;
    grt      = '0;
    acc      = 1'b0;
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (|req) begin
          own_d    = win;
          vc_own_d = win_vc;
          state_d  = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        grt[own_q] = cred_ok;
        acc        = cred_ok & ivalid[own_q];
        if (acc) begin
          odata_d  = own_flit;
          ovalid_d = 1'b1;
          ovch_d   = vc_own_q;
          if (own_flit[`TYPE_MSB:`TYPE_LSB] == `TYPE_TAIL) begin
            state_d  = IDLE;
            rr_ptr_d = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
      vc_own_q <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      own_q    <= own_d;
      vc_own_q <= vc_own_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

`ifdef PE_ARB_CREDIT_EN
  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] credit_q [2];
  logic          err_q;
  logic [1:0]    dec;

  assign dec     = {acc & vc_own_q[0], acc & ~vc_own_q[0]};
  assign cred_ok = (credit_q[vc_own_q[0]] != '0);

  // A return that coincides with a send cancels out; a return into a full counter is an overflow.
  always_ff @(posedge clk) begin
    if (rst_) begin
      credit_q[0] <= CW'(CREDITS);
      credit_q[1] <= CW'(CREDITS);
      err_q       <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (icredit[v] && !dec[v]) begin
          if (credit_q[v] == CW'(CREDITS)) err_q <= 1'b1;
          else credit_q[v] <= credit_q[v] + 1'b1;
        end else if (dec[v] && !icredit[v]) begin
          credit_q[v] <= credit_q[v] - 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  localparam int UNUSED_CREDITS = CREDITS;
  logic unused_icredit;

  assign unused_icredit = ^icredit;
  assign cred_ok        = 1'b1;
  assign err            = 1'b0;
`endif

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;
  assign state  = state_q;

endmodule

// File: tb/tb_pe_inj_arb.sv
// tb_pe_inj_arb: scoreboard bench for pe_inj_arb; a packet-level round-robin model predicts the flit
// stream, a monitor pops predictions on every ovalid. Credit cases run when PE_ARB_CREDIT_EN is defined.
`timescale 1ns/1ps
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b11
`endif

module tb_pe_inj_arb;
  localparam int NREQ    = 4;
  localparam int CREDITS = 4;
  localparam int FW      = `DATAW + 1;
  localparam int VW      = `VCHW + 1;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [VW-1:0] v;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst_ = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*FW-1:0]   idata;
  logic [NREQ-1:0]      ivalid;
  logic [NREQ*VW-1:0]   ivch;
  logic [1:0]           icredit;
  logic [NREQ-1:0]      grt;
  logic [FW-1:0]        odata;
  logic                 ovalid;
  logic [VW-1:0]        ovch;
  logic [1:0]           state;
  logic                 err;

  ent_t pq[NREQ][$];   // what each requester still has to send
  ent_t mq[NREQ][$];   // model copy, consumed by run_model
  ent_t exp_q[$];
  int   ret_q[2][$];

  int errors = 0, checks = 0, cyc = 0, out_cnt = 0, streak = 0, max_streak = 0;
  int vld_pct = 100, model_ptr = 0;
  bit auto_credit = 1'b0, last_acc = 1'b0;

  pe_inj_arb #(.NREQ(NREQ), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_(rst_), .req(req), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .icredit(icredit), .grt(grt), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_pkt(int r, int len, logic [VW-1:0] vc);
    ent_t e;
    for (int j = 0; j < len; j++) begin
      e.d = FW'($urandom);
      e.d[`TYPE_MSB:`TYPE_LSB] = (j == len - 1) ? T_TAIL : ((j == 0) ? T_HEAD : T_BODY);
      e.v = vc;
      pq[r].push_back(e);
      mq[r].push_back(e);
    end
  endtask

  // Packet-level round robin: whole packets, one at a time, next search starts after the last winner.
  task automatic run_model();
    int   w, c;
    ent_t e;
    while (1) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (model_ptr + k) % NREQ;
        if (w < 0 && mq[c].size() != 0) w = c;
      end
      if (w < 0) break;
      do begin
        e = mq[w].pop_front();
        exp_q.push_back(e);
      end while (e.d[`TYPE_MSB:`TYPE_LSB] != T_TAIL);
      model_ptr = (w + 1) % NREQ;
    end
  endtask

  function automatic bit drained();
    bit d = (exp_q.size() == 0);
    for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_drain(int bound, string name);
    for (int n = 0; n < bound; n++) begin
      if (drained()) break;
      @(negedge clk); #1;
    end
    checks++;
    if (!drained()) begin
      errors++;
      $display("FAIL %s: timeout, got %0d flits pending required 0", name, exp_q.size());
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      pq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    ret_q[0].delete();
    ret_q[1].delete();
    model_ptr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_ = 1'b1;
    step(1);
    clear_all();
    step(1);
    rst_ = 1'b0;
  endtask

  // Requester/router driver: retires accepted flits, presents queue heads, returns credits.
  initial begin : drv
    logic [NREQ-1:0] acc;
    logic            rst_edge;
    forever begin
      @(negedge clk);
      acc = grt & ivalid;
      @(posedge clk);
      rst_edge = rst_;
      #1;
      cyc++;
      last_acc = (|acc) && !rst_edge;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst_edge && acc[i] && pq[i].size() != 0) pq[i].delete(0);
        req[i]    = (pq[i].size() != 0);
        ivalid[i] = req[i] && ($urandom_range(99, 0) < vld_pct);
        idata[i*FW +: FW] = req[i] ? pq[i][0].d : '0;
        ivch[i*VW +: VW]  = req[i] ? pq[i][0].v : '0;
      end
      if (auto_credit) begin
`ifdef PE_ARB_CREDIT_EN
        for (int v = 0; v < 2; v++) begin
          icredit[v] = (ret_q[v].size() != 0) && (ret_q[v][0] <= cyc);
          if (icredit[v]) ret_q[v].delete(0);
        end
`else
        icredit = 2'($urandom);
`endif
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : mon
    ent_t e;
    forever begin
      @(negedge clk);
      chk("ovalid_latency", ovalid, last_acc);
      chk("grt_onehot0", $onehot0(grt), 1);
      if (state != 2'b10) chk("grt_zero_outside_xfer", grt, 0);
      if (ovalid) begin
        out_cnt++;
        streak++;
        if (streak > max_streak) max_streak = streak;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got %0h required no flit", odata);
        end else begin
          e = exp_q.pop_front();
          chk("odata", odata, e.d);
          chk("ovch", ovch, e.v);
        end
        if (auto_credit) ret_q[ovch].push_back(cyc + $urandom_range(6, 1));
      end else begin
        streak = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c0, np;
    req = '0; idata = '0; ivalid = '0; ivch = '0; icredit = '0;
    do_reset();
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_grt", grt, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_ovch", ovch, 0);
    chk("rst_err", err, 0);
    repeat (10) begin
      @(negedge clk);
      chk("idle_state", state, 0);
      chk("idle_grt", grt, 0);
      chk("idle_ovalid", ovalid, 0);
    end

    // Requesters 0 and 2, then 0 and 3 to show the pointer moved past 2.
    auto_credit = 1'b1;
    vld_pct = 100;
    @(posedge clk); #2;
    load_pkt(0, 3, 0);
    load_pkt(2, 3, 1);
    run_model();
    wait_drain(60, "rr_0101");
    step(1);
    load_pkt(0, 2, 1);
    load_pkt(3, 2, 0);
    run_model();
    wait_drain(60, "rr_ptr3");

    for (int b = 0; b < 8; b++) begin
      step(1);
      vld_pct = $urandom_range(100, 30);
      for (int r = 0; r < NREQ; r++) begin
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) load_pkt(r, $urandom_range(5, 1), VW'($urandom_range(1, 0)));
      end
      run_model();
      wait_drain(600, "random_drain");
    end
    vld_pct = 100;

`ifdef PE_ARB_CREDIT_EN
    chk("err_after_traffic", err, 0);
    // Credit exhaustion: 6-flit packet, no returns.
    do_reset();
    auto_credit = 1'b0;
    icredit = 2'b00;
    c0 = out_cnt;
    load_pkt(1, 6, 0);
    run_model();
    step(14);
    @(negedge clk); #1;
    chk("stall_count", out_cnt - c0, 4);
    chk("stall_grt", grt, 0);
    chk("stall_state", state, 2);
    @(posedge clk); #2; icredit = 2'b01;
    @(posedge clk); #2; icredit = 2'b00;
    @(negedge clk);
    chk("credit_grt", grt, 4'b0010);
    @(negedge clk); #1;
    chk("credit_one_flit", out_cnt - c0, 5);
    chk("credit_grt_off", grt, 0);
    step(3);
    chk("credit_still_five", out_cnt - c0, 5);
    icredit = 2'b01;
    step(1);
    icredit = 2'b00;
    wait_drain(20, "credit_tail");

    // Overflow: return into a full counter.
    do_reset();
    @(posedge clk); #2; icredit = 2'b01;
    @(posedge clk); #2; icredit = 2'b00;
    @(negedge clk);
    chk("err_set", err, 1);
    step(5);
    @(negedge clk);
    chk("err_hold", err, 1);
    c0 = out_cnt;
    step(1);
    load_pkt(1, 6, 0);
    run_model();
    step(14);
    @(negedge clk); #1;
    chk("saturated_count", out_cnt - c0, 4);
    chk("err_still", err, 1);
`endif

    // Reset while the 2nd flit of a packet is being accepted.
    do_reset();
    auto_credit = 1'b0;
    icredit = 2'b00;
    c0 = out_cnt;
    load_pkt(0, 3, 1);
    run_model();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (out_cnt - c0 >= 1) break;
    end
    chk("first_flit_seen", out_cnt - c0, 1);
    rst_ = 1'b1;
    @(negedge clk);
    chk("midrst_state", state, 0);
    chk("midrst_grt", grt, 0);
    chk("midrst_ovalid", ovalid, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); #2;
    clear_all();
    step(1);
    rst_ = 1'b0;
`ifdef PE_ARB_CREDIT_EN
    c0 = out_cnt;
    load_pkt(3, 6, 1);
    run_model();
    step(14);
    @(negedge clk); #1;
    chk("midrst_credit4", out_cnt - c0, 4);
    do_reset();
`else
    // Credits disabled: long packet streams back-to-back despite random icredit.
    auto_credit = 1'b1;
    step(1);
    max_streak = 0;
    c0 = out_cnt;
    load_pkt(2, 10, 0);
    run_model();
    wait_drain(60, "b2b_drain");
    @(negedge clk); #1;
    chk("b2b_count", out_cnt - c0, 10);
    chk("b2b_streak", max_streak, 10);
    chk("b2b_err", err, 0);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_inj_arb.md
PE_INJ_ARB -- requirements
Module: pe_inj_arb

Interface
- REQ-001 Parameter NREQ, default 4, number of PE requesters sharing one router injection port.
- REQ-002 Parameter CREDITS, default 4, downstream buffer depth per VC.
- REQ-003 Flit width is `DATAW+1`; VC index width is `VCHW+1`; both come from define.v.
- REQ-004 Port clk, input, 1, single clock; all logic updates on the posedge.
- REQ-005 Port rst_, input, 1, synchronous active-high reset (1 = reset).
- REQ-006 Port req, input, NREQ, per-requester packet-pending request.
- REQ-007 Port idata, input, NREQ*(`DATAW+1`), packed flits; requester i occupies slice i.
- REQ-008 Port ivalid, input, NREQ, per-requester flit valid.
- REQ-009 Port ivch, input, NREQ*(`VCHW+1`), per-requester target VC, sampled at grant.
- REQ-010 Port icredit, input, 2, per-VC credit return pulse from the router.
- REQ-011 Port grt, output, NREQ, per-requester accept; a flit transfers when ivalid[i] and grt[i] are both 1.
- REQ-012 Port odata, output, `DATAW+1`, flit to the router.
- REQ-013 Port ovalid, output, 1, odata valid.
- REQ-014 Port ovch, output, `VCHW+1`, VC of odata.
- REQ-015 Port state, output, 2, FSM state: IDLE=00, ARB=01, XFER=10.
- REQ-016 Port err, output, 1, sticky credit-overflow flag.

Function
- REQ-017 IDLE: goes to ARB when any req bit is 1; otherwise stays in IDLE.
- REQ-018 ARB, one cycle: picks the winner w = first set req bit at or after rr_ptr (wrapping NREQ-1 to 0), latches vc_own = ivch[w], then enters XFER; if req has fallen to 0, returns to IDLE.
- REQ-019 XFER: grt[w] = (credit[vc_own] != 0); all other grt bits are 0; grt is combinational from registered state only and does not depend on ivalid.
- REQ-020 Accepted flit: odata/ovalid/ovch present idata[w]/1/vc_own exactly 1 cycle after acceptance; otherwise ovalid = 0 and odata holds its last value.
- REQ-021 When an accepted flit has type field [`TYPE_MSB:`TYPE_LSB] == `TYPE_TAIL`, the next state is IDLE and rr_ptr = (w+1) mod NREQ; a single-flit packet carries the tail type.
- REQ-022 Ownership persists until the tail flit; deasserting req[w] mid-packet has no effect on ownership.
- REQ-023 credit[v]: decrements on an accepted flit to VC v, increments on icredit[v]; simultaneous decrement and increment leaves it unchanged.
- REQ-024 Zero credit stalls: grt[w] = 0 and no flit transfers until credit returns; the owner is kept.
- REQ-025 An increment at credit == CREDITS saturates the counter and sets err = 1, which holds until reset.
- REQ-026 grt is one-hot or zero in every cycle; it is all-zero in IDLE and ARB.

Reset
- REQ-027 While rst_ = 1 at a posedge, the following clear: state=IDLE, rr_ptr=0, grt=0, odata=0, ovalid=0, ovch=0, err=0, credit[0]=credit[1]=CREDITS.
- REQ-028 Reset mid-packet abandons the packet with no tail emitted; the requester FIFOs are the owners' concern.

Configuration
- REQ-029 Macro PE_ARB_CREDIT_EN: when defined, credit counters and err behave as in REQ-019/REQ-023..REQ-025.
- REQ-030 When PE_ARB_CREDIT_EN is undefined, credits are treated as always nonzero, icredit is ignored, err is tied to 0, and no counter logic is generated.

Verification
- REQ-031 Reset, then req=4'b0000 for 10 cycles -> state=00, grt=0, ovalid=0 throughout.
- REQ-032 req=4'b0101, 3-flit packets (head, body, tail) from both -> requester 0 is served first; after its tail, requester 2 is served; rr_ptr=3; no flit interleaving.
- REQ-033 CREDITS=4, requester 1 sends a 6-flit packet with no icredit -> 4 flits are forwarded, then grt[1]=0; an icredit pulse on that VC -> exactly 1 more flit is forwarded, 1 cycle later.
- REQ-034 icredit[0] pulsed while credit[0]=4 -> credit stays 4, err=1 next cycle and stays set.
- REQ-035 rst_=1 asserted during the 2nd flit of a packet -> next cycle state=00, grt=0, ovalid=0, credits=4.
- REQ-036 Build without PE_ARB_CREDIT_EN, 10-flit packet with icredit=0 -> all 10 flits are forwarded back-to-back, err=0.
